hdmi_link_sequencer: RTL

//  Power-up and recovery sequencer for the HDMI colorbar path, clocked by pixel_clk.

---
 rtl/hdmi_link_sequencer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/hdmi_link_sequencer.sv
// Power-up and recovery sequencer for the HDMI colorbar path (pixel_clk domain).
// Optional vsync watchdog enabled by defining HDMI_SEQ_WATCHDOG_EN.
module hdmi_link_sequencer #(
  parameter int unsigned LOCK_STABLE_CYC = 1024,
  parameter int unsigned WARMUP_FRAMES   = 2,
  parameter bit          VS_ACTIVE_HIGH  = 1'b1,
  parameter int unsigned WDOG_CYC        = 2000000
) (
  input  logic       pixel_clk,
  input  logic       sys_rst_n,
  input  logic       clk_locked,
  input  logic       video_vs,
  input  logic       enable_req,
  output logic       drv_rst_n,
  output logic       tmds_oen,
  output logic       mute,
  output logic [2:0] link_state,
  output logic [7:0] lock_lost_cnt,
  output logic       wdog_trip
);

  localparam int unsigned LockW  = (LOCK_STABLE_CYC > 1) ? $clog2(LOCK_STABLE_CYC) : 1;
  localparam int unsigned FrameW = (WARMUP_FRAMES > 1) ? $clog2(WARMUP_FRAMES) : 1;
  localparam logic [LockW-1:0]  LockLast  = LockW'(LOCK_STABLE_CYC - 1);
  localparam logic [FrameW-1:0] FrameLast = FrameW'(WARMUP_FRAMES - 1);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StLockWait = 3'd1,
    StWarmup   = 3'd2,
    StStandby  = 3'd3,
    StActive   = 3'd4
  } state_e;

  state_e            state_q;
  logic [LockW-1:0]  lock_cnt_q;
  logic [FrameW-1:0] frame_cnt_q;
  logic              lock_meta_q, lock_s_q;
  logic              vs_act, vs_act_q, vs_edge;
  logic              run;
  logic              wdog_hit;

  assign vs_act  = video_vs ^ ~VS_ACTIVE_HIGH;
  assign vs_edge = vs_act & ~vs_act_q;
  assign run     = (state_q == StWarmup) || (state_q == StStandby) || (state_q == StActive);

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      vs_act_q    <= 1'b0;
    end else begin
      lock_meta_q <= clk_locked;
      lock_s_q    <= lock_meta_q;
      vs_act_q    <= vs_act;
    end
  end

`ifdef HDMI_SEQ_WATCHDOG_EN
  localparam int unsigned WdogW = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;
  localparam logic [WdogW-1:0] WdogLast = WdogW'(WDOG_CYC - 1);

  logic [WdogW-1:0] wdog_cnt_q;

  // A vsync edge in the same cycle as expiry counts as a frame arriving in time.
  assign wdog_hit = (wdog_cnt_q == WdogLast) & ~vs_edge;

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wdog_cnt_q <= '0;
      wdog_trip  <= 1'b0;
    end else begin
      if (!run || vs_edge) begin
        wdog_cnt_q <= '0;
      end else if (!wdog_hit) begin
        wdog_cnt_q <= wdog_cnt_q + 1'b1;
      end
      if (run && lock_s_q && wdog_hit) begin
        wdog_trip <= 1'b1;
      end
    end
  end
`else
  logic unused_wdog;
  assign unused_wdog = ^WDOG_CYC;
  assign wdog_hit    = 1'b0;
  assign wdog_trip   = 1'b0;
`endif

  // Outputs decode the current state register, so they trail it by one cycle.
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= StIdle;
      lock_cnt_q    <= '0;
      frame_cnt_q   <= '0;
      lock_lost_cnt <= 8'd0;
      drv_rst_n     <= 1'b0;
      tmds_oen      <= 1'b0;
      mute          <= 1'b1;
      link_state    <= 3'd0;
    end else begin
      drv_rst_n  <= run;
      tmds_oen   <= run;
      mute       <= (state_q != StActive);
      link_state <= state_q;
      unique case (state_q)
        StIdle: begin
          if (lock_s_q) begin
            state_q    <= StLockWait;
            lock_cnt_q <= '0;
          end
        end
        StLockWait: begin
          if (!lock_s_q) begin
            state_q <= StIdle;
          end else if (lock_cnt_q == LockLast) begin
            state_q     <= StWarmup;
            frame_cnt_q <= '0;
          end else begin
            lock_cnt_q <= lock_cnt_q + 1'b1;
          end
        end
        StWarmup, StStandby, StActive: begin
          if (!lock_s_q) begin
            state_q <= StIdle;
            if (lock_lost_cnt != 8'hFF) begin
              lock_lost_cnt <= lock_lost_cnt + 8'd1;
            end
          end else if (wdog_hit) begin
            state_q <= StIdle;
          end else if (vs_edge) begin
            if (state_q == StWarmup) begin
              if (frame_cnt_q == FrameLast) begin
                state_q <= enable_req ? StActive : StStandby;
              end else begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
              end
            end else begin
              state_q <= enable_req ? StActive : StStandby;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
